// File: rtl/note_sequencer.sv
// note_sequencer: plays a 16-step melody into a tone oscillator.
// Ports: clk, rst_n (sync, low); start/stop/loop_en/seq_last control;
//   wr_en/wr_addr/wr_data program the step memory (idle only);
//   load/note strobe the oscillator; busy, done, step report status.
module note_sequencer #(
  parameter int TICK_DIV = 3_125_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [3:0] seq_last,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       load,
  output logic [4:0] note,
  output logic       busy,
  output logic       done,
  output logic [3:0] step
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    FINISH
  } state_t;

  state_t        state;
  logic [7:0]    mem [16];
  logic [3:0]    last;
  logic [2:0]    dur;
  logic [TW-1:0] tick;

  logic          wrap;
  logic [3:0]    step_nx;
  logic [4:0]    first_note;

  assign wrap    = (tick == TICK_MAX);
  assign step_nx = step + 4'd1;

  // A write accepted alongside start must already be visible to step 0.
  assign first_note = (wr_en && wr_addr == 4'd0) ?
                      wr_data[4:0] : mem[0][4:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      load  <= 1'b0;
      note  <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      step  <= 4'd0;
      last  <= 4'd0;
      dur   <= 3'd0;
      tick  <= '0;
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_en) begin
            mem[wr_addr] <= wr_data;
          end
          if (start && !stop) begin
            last  <= seq_last;
            step  <= 4'd0;
            note  <= first_note;
            load  <= 1'b1;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          dur  <= mem[step][7:5];
          tick <= '0;
          if (stop) begin
            load  <= 1'b1;
            note  <= 5'd0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          tick <= wrap ? '0 : tick + 1'b1;
          if (stop) begin
            load  <= 1'b1;
            note  <= 5'd0;
            done  <= 1'b1;
            state <= FINISH;
          end else if (wrap) begin
            if (dur != 3'd0) begin
              dur <= dur - 3'd1;
            end else if (step != last) begin
              step  <= step_nx;
              note  <= mem[step_nx][4:0];
              load  <= 1'b1;
              state <= LOAD;
            end else if (loop_en) begin
              step  <= 4'd0;
              note  <= mem[0][4:0];
              load  <= 1'b1;
              state <= LOAD;
            end else begin
              load  <= 1'b1;
              note  <= 5'd0;
              done  <= 1'b1;
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed + random checks of note_sequencer
// against a strobe-timestamp model of the melody playback.
module tb_note_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, loop_en, wr_en;
  logic [3:0] seq_last, wr_addr;
  logic [7:0] wr_data;
  logic       load, busy, done;
  logic [4:0] note;
  logic [3:0] step;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  note_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .loop_en(loop_en), .seq_last(seq_last), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .load(load),
    .note(note), .busy(busy), .done(done), .step(step)
  );

  always #5 clk = ~clk;

  // Model: playback described by strobe timestamps. A step with
  // duration code d strobed at edge e is followed by the next strobe
  // at edge e + 1 + (d+1)*TD; stop forces the silencing strobe.
  logic [7:0] mm [16];
  logic       m_load, m_busy, m_done;
  logic [4:0] m_note;
  logic [3:0] m_step, m_last;
  int         mode = 0;  // 0 idle, 1 playing, 2 silencing
  int         e = 0;
  int         next_e = 0;

  task automatic m_strobe(input logic [3:0] s);
    m_step = s;
    m_note = mm[s][4:0];
    m_load = 1'b1;
    next_e = e + 1 + (int'(mm[s][7:5]) + 1) * TD;
  endtask

  task automatic m_fin();
    m_load = 1'b1;
    m_note = 5'd0;
    m_done = 1'b1;
    mode   = 2;
  endtask

  always @(posedge clk) begin
    e++;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mm[i] = 8'h00;
      mode = 0;
      m_load = 0; m_busy = 0; m_done = 0;
      m_note = 0; m_step = 0; m_last = 0;
    end else begin
      m_load = 0;
      m_done = 0;
      if (mode == 2) begin
        m_busy = 0;
        mode = 0;
      end else if (mode == 1) begin
        if (stop) m_fin();
        else if (e == next_e) begin
          if (m_step != m_last) m_strobe(m_step + 4'd1);
          else if (loop_en) m_strobe(4'd0);
          else m_fin();
        end
      end else begin
        if (wr_en) mm[wr_addr] = wr_data;
        if (start && !stop) begin
          m_last = seq_last;
          m_busy = 1;
          mode = 1;
          m_strobe(4'd0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ({load, note, busy, done, step} !==
          {m_load, m_note, m_busy, m_done, m_step}) begin
        bad++;
        $display("FAIL model t=%0t got l=%b n=%0d b=%b d=%b s=%0d exp l=%b n=%0d b=%b d=%b s=%0d",
                 $time, load, note, busy, done, step,
                 m_load, m_note, m_busy, m_done, m_step);
      end
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    adv(1);
    wr_en = 0;
  endtask

  task automatic go();
    start = 1;
    adv(1);
    start = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; stop = 0; loop_en = 0;
    seq_last = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    adv(3);
    rst_n = 1;
    chk("rst_load", {7'd0, load}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_step", {4'd0, step}, 8'd0);
    chk_en = 1;

    // single step: 0x4A -> note 10, d=2
    wr(0, 8'h4A);
    seq_last = 0;
    go();
    chk("ss_load", {7'd0, load}, 8'd1);
    chk("ss_note", {3'd0, note}, 8'd10);
    adv(12);
    chk("ss_quiet", {7'd0, load}, 8'd0);
    adv(1);
    chk("ss_fin", {5'd0, load, done, busy}, 8'b111);
    chk("ss_fnote", {3'd0, note}, 8'd0);
    adv(1);
    chk("ss_idle", {6'd0, busy, done}, 8'd0);

    // multi-step: strobes at 1, 6, 15, 20
    wr(0, 8'h01); wr(1, 8'h22); wr(2, 8'h03);
    seq_last = 2;
    go();
    chk("ms_s0", {load, note, 2'd0}, {1'b1, 5'd1, 2'd0});
    adv(5);
    chk("ms_s1", {load, note, 2'd0}, {1'b1, 5'd2, 2'd0});
    chk("ms_st1", {4'd0, step}, 8'd1);
    adv(9);
    chk("ms_s2", {load, note, 2'd0}, {1'b1, 5'd3, 2'd0});
    chk("ms_st2", {4'd0, step}, 8'd2);
    adv(5);
    chk("ms_fin", {load, note, done, 1'b0}, {1'b1, 5'd0, 1'b1, 1'b0});
    adv(1);

    // loop once, then clear loop_en
    loop_en = 1;
    go();
    adv(19);
    chk("lp_wrap", {load, note, done, step[0]},
        {1'b1, 5'd1, 1'b0, 1'b0});
    chk("lp_step", {4'd0, step}, 8'd0);
    loop_en = 0;
    adv(14);
    chk("lp_s2", {load, note, 2'd0}, {1'b1, 5'd3, 2'd0});
    adv(5);
    chk("lp_fin", {load, note, done, 1'b0}, {1'b1, 5'd0, 1'b1, 1'b0});
    adv(1);

    // stop at cycle 8
    go();
    adv(7);
    stop = 1;
    adv(1);
    stop = 0;
    chk("sp_fin", {load, note, done, 1'b0}, {1'b1, 5'd0, 1'b1, 1'b0});
    adv(1);
    chk("sp_busy", {7'd0, busy}, 8'd0);

    // start held while playing: no restart
    start = 1;
    adv(1);
    adv(5);
    chk("sh_st1", {4'd0, step}, 8'd1);
    start = 0;
    adv(14);
    chk("sh_fin", {7'd0, done}, 8'd1);
    adv(1);

    // start and stop together in idle
    start = 1; stop = 1;
    adv(1);
    chk("ss_none", {6'd0, load, busy}, 8'd0);
    start = 0; stop = 0;
    adv(2);

    // write while busy is dropped
    go();
    wr_en = 1; wr_addr = 0; wr_data = 8'h1F;
    adv(3);
    wr_en = 0;
    adv(25);
    go();
    chk("wg_keep", {3'd0, note}, 8'd1);
    adv(25);
    // write together with start: step 0 sees the new value
    wr_en = 1; wr_addr = 0; wr_data = 8'h05; start = 1;
    adv(1);
    wr_en = 0; start = 0;
    chk("wg_fwd", {3'd0, note}, 8'd5);
    adv(25);

    // reset mid-HOLD clears memory and outputs
    go();
    adv(3);
    rst_n = 0;
    adv(1);
    chk("rm_out", {load, note, busy, done}, 8'd0);
    chk("rm_step", {4'd0, step}, 8'd0);
    rst_n = 1;
    go();
    chk("rm_sil", {load, note, busy, 1'b0}, {1'b1, 5'd0, 1'b1, 1'b0});
    adv(20);

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      rst_n    = ($urandom_range(0, 999) != 0);
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 59) == 0);
      loop_en  = ($urandom_range(0, 3) != 0);
      seq_last = 4'($urandom_range(0, 15));
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = 8'($urandom_range(0, 255));
      adv(1);
    end
    rst_n = 1; start = 0; stop = 0; wr_en = 0;
    adv(2);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays a short programmable melody by driving the `load`/`note` inputs of the downstream tone oscillator. A 16-entry step memory holds note code and duration per step. A tempo divider paces the steps, and a small FSM handles start, stop, looping and end-of-sequence silencing. Sits directly upstream of the oscillator, on the same 50 MHz clock.

## Interface
- `TICK_DIV`, default 3_125_000: clock cycles per tempo tick (16 ticks/s at 50 MHz); must be ≥ 2.
- `clk` in 1: system clock, 50 MHz; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: level sampled each cycle; begins playback from step 0 when idle.
- `stop` in 1: aborts playback; silences the output.
- `loop_en` in 1: sampled at end of the last step; 1 = restart at step 0.
- `seq_last` in 4: index of the final step; captured on accepted `start`.
- `wr_en` in 1: step-memory write strobe.
- `wr_addr` in 4: step-memory write address.
- `wr_data` in 8: step entry. [4:0] = note code (0 = rest/silence); [7:5] = duration code d (d+1 ticks).
- `load` out 1: one-cycle strobe to the oscillator; `note` is valid in this cycle.
- `note` out 5: current note code; holds its value between strobes.
- `busy` out 1: high while playing.
- `done` out 1: one-cycle pulse when playback ends (completion or stop).
- `step` out 4: index of the step currently sounding.

## Operation
- Reset (`rst_n`=0 at an edge): `load`=0, `note`=0, `busy`=0, `done`=0, `step`=0, all 16 memory entries = 0x00, tick and duration counters = 0, FSM = IDLE.
- Step memory: 16×8 registers, written when `wr_en`=1 and FSM is IDLE.
  - Writes while `busy`=1 are dropped.
  - A write and an accepted `start` in the same cycle: the write commits first, and step 0 reads the new value.
- FSM states: IDLE, LOAD, HOLD, FINISH.
- IDLE:
  - `start`=1 and `stop`=0 → capture `seq_last`, `step`←0, go to LOAD.
  - `start` and `stop` both 1 → no action.
- LOAD (one cycle):
  - `load`=1, `note`=mem[step][4:0], `busy`=1.
  - Duration counter ← mem[step][7:5]; tick counter ← 0. Go to HOLD.
- HOLD:
  - Tick counter counts 0..TICK_DIV-1 and wraps.
  - At each wrap: if duration counter = 0, the step is complete; otherwise decrement it.
  - Step complete with `step` ≠ captured last → `step`+1, go to LOAD.
  - Step complete with `step` = last and `loop_en`=1 → `step`←0, go to LOAD.
  - Step complete with `step` = last and `loop_en`=0 → go to FINISH.
- FINISH (one cycle): `load`=1, `note`=0, `done`=1, `busy`←0 next cycle, go to IDLE.
- `stop`=1 in LOAD or HOLD: the next state is FINISH, regardless of counters.
- `start` while busy is ignored. `seq_last` changes while busy are ignored.
- Note code 0 inside a sequence is a normal rest step; it is strobed like any other note.
- `step` wraps naturally; with `seq_last`=15 the steps run 0..15.

## Timing
- Accepted `start` in cycle N: LOAD in cycle N+1, so the first `load` strobe appears in N+1.
- Strobe spacing: step k strobes at cycle L, and the next strobe (LOAD or FINISH) is at L + 1 + (d_k+1)·TICK_DIV.
  - HOLD lasts exactly (d+1)·TICK_DIV cycles.
- `busy` rises in the LOAD cycle and falls the cycle after FINISH.
- `done` is coincident with the silencing `load`.
- `stop` asserted in cycle S during LOAD/HOLD: FINISH in S+1, and `busy`=0 in S+2.
- `rst_n` low mid-playback: all outputs take reset values on that edge. No FINISH strobe is emitted; the oscillator is reset separately.
- Counters must fit ⌈log2 TICK_DIV⌉ bits; no overflow beyond TICK_DIV-1.

## Test plan
- Reset: run with TICK_DIV=4, assert `rst_n`=0 mid-HOLD → next cycle `load`=0, `note`=0, `busy`=0, `step`=0; a following `start` plays silence (memory cleared).
- Single step: mem[0]=0x4A (note 10, d=2), `seq_last`=0, `loop_en`=0, `start` at cycle 10.
  - `load` with `note`=10 at cycle 11.
  - FINISH at cycle 24: `load`=1, `note`=0, `done`=1.
  - `busy`=0 at cycle 25.
- Multi-step: mem[0..2]=0x01, 0x22, 0x03, `seq_last`=2, `start` at cycle 0 → strobes at cycles 1, 6, 15, 20.
  - Notes 1, 2, 3, then 0 with `done`.
  - `step` reads 0, 1, 2.
- Loop: same program with `loop_en`=1 → strobe at cycle 20 carries `note`=1 and `step`=0, with no `done`. Clearing `loop_en` before the next end-of-sequence → FINISH follows step 2.
- Stop and start contention:
  - `stop` at cycle 8 of a playing sequence → `load`/`note`=0/`done` at cycle 9.
  - `start` held high during playback → no restart.
  - `start` and `stop` together in IDLE → no strobe.
- Write gating: `wr_en` to addr 0 while busy → memory unchanged after playback. Write addr 0 = 0x05 in the same cycle as `start` → first strobe has `note`=5.
